// File: rtl/instr_mem_prog.sv
// ---------------------------------------------------------------------------
// instr_mem_prog
// Loadable instruction memory for the MIPS fetch stage.
//
// After reset the whole array is cleared to NOP (one word per cycle). Then the
// block runs and serves fetches. A host may open a load session at any time
// while running and stream program bytes in big-endian order.
//
// Ports:
//   clk          system clock, rising edge
//   resetN       synchronous active-low reset
//   PC           byte address to fetch
//   fetch_req    fetch request, PC sampled when high
//   instruction  fetched word (0 on fault, holds when idle)
//   instr_valid  instruction/fault valid this cycle (1-cycle latency)
//   fault        fetch was misaligned or out of range
//   busy         clearing or loading, fetches dropped
//   prog_start   pulse: open a load session (RUN only)
//   prog_valid   prog_byte valid
//   prog_byte    program byte, MSB-first within each word
//   prog_ready   byte accepted this cycle when prog_valid is high
//   prog_done    pulse: close the load session (LOAD only)
//   loaded_words words written in the last load session
// ---------------------------------------------------------------------------
module instr_mem_prog #(
    parameter int          MEM_SIZE  = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         AW        = $clog2(MEM_SIZE)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic [31:0]   PC,
    input  logic          fetch_req,
    output logic [31:0]   instruction,
    output logic          instr_valid,
    output logic          fault,
    output logic          busy,
    input  logic          prog_start,
    input  logic          prog_valid,
    input  logic [7:0]    prog_byte,
    output logic          prog_ready,
    input  logic          prog_done,
    output logic [AW:0]   loaded_words
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [31:0]     r_mem [MEM_SIZE];

    logic [AW-1:0]   r_clr_ptr;
    logic [AW:0]     r_wptr;
    logic [AW:0]     w_wptr_next;
    logic [1:0]      r_bc;
    logic [31:0]     r_asm;
    logic [31:0]     w_asm_new;
    logic [AW:0]     r_loaded;

    logic            w_in_load;
    logic            w_room;
    logic            w_accept;
    logic            w_word_full;
    logic            w_partial;
    logic            w_load_we;

    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [31:0]     w_wdata;

    logic [31:0]     w_offset;
    logic [AW-1:0]   w_ridx;
    logic            w_bad;
    logic            w_fetch;

    logic [31:0]     r_instruction;
    logic            r_instr_valid;
    logic            r_fault;

    // ------------------------------------------------------------------
    // Load datapath
    // ------------------------------------------------------------------
    assign w_in_load = (r_state == S_LOAD);
    // wptr's top bit set means wptr == MEM_SIZE: the array is full.
    assign w_room    = ~r_wptr[AW];
    assign w_accept  = w_in_load && prog_valid && w_room;

    // Assembly register is kept zero below the current byte slot, so
    // OR-ing the shifted byte in places it and leaves the zero padding.
    assign w_asm_new = w_accept ? (r_asm | ({prog_byte, 24'h0} >> {r_bc, 3'b000}))
                                : r_asm;

    assign w_word_full = w_accept && (r_bc == 2'd3);
    // A partial word is flushed at session close if any byte is pending,
    // counting a byte accepted in the closing cycle itself.
    assign w_partial   = w_in_load && prog_done && !w_word_full && w_room
                         && (w_accept || (r_bc != 2'd0));
    assign w_load_we   = w_word_full || w_partial;
    assign w_wptr_next = r_wptr + {{AW{1'b0}}, w_load_we};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_ptr == AW'(MEM_SIZE - 1)) w_state_next = S_RUN;
            S_RUN:   if (prog_start)                     w_state_next = S_LOAD;
            S_LOAD:  if (prog_done)                      w_state_next = S_RUN;
            default:                                     w_state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_wptr    <= '0;
            r_bc      <= '0;
            r_asm     <= '0;
            r_loaded  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + AW'(1);
            end
            case (r_state)
                S_RUN: begin
                    if (prog_start) begin
                        r_wptr   <= '0;
                        r_bc     <= '0;
                        r_asm    <= '0;
                        r_loaded <= '0;
                    end
                end
                S_LOAD: begin
                    r_wptr <= w_wptr_next;
                    if (prog_done || w_word_full) begin
                        r_bc  <= '0;
                        r_asm <= '0;
                    end else if (w_accept) begin
                        r_bc  <= r_bc + 2'd1;
                        r_asm <= w_asm_new;
                    end
                    if (prog_done) begin
                        r_loaded <= w_wptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory write port: clear and load never coexist, one writer per cycle
    // ------------------------------------------------------------------
    assign w_we    = resetN && ((r_state == S_CLEAR) || (w_in_load && w_load_we));
    assign w_waddr = (r_state == S_CLEAR) ? r_clr_ptr : r_wptr[AW-1:0];
    assign w_wdata = (r_state == S_CLEAR) ? 32'h0 : w_asm_new;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Fetch port
    // ------------------------------------------------------------------
    // Unsigned wrap makes PCs below BASE_ADDR land far out of range.
    assign w_offset = PC - BASE_ADDR;
    assign w_ridx   = w_offset[AW+1:2];
    assign w_bad    = (PC[1:0] != 2'b00) || ((w_offset >> 2) >= 32'(MEM_SIZE));
    assign w_fetch  = fetch_req && (r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch;
            r_fault       <= w_fetch && w_bad;
            if (w_fetch) begin
                r_instruction <= w_bad ? 32'h0 : r_mem[w_ridx];
            end
        end
    end

    assign instruction  = r_instruction;
    assign instr_valid  = r_instr_valid;
    assign fault        = r_fault;
    assign busy         = (r_state != S_RUN);
    assign prog_ready   = w_in_load && w_room;
    assign loaded_words = r_loaded;

endmodule

// File: tb/tb_instr_mem_prog.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_prog
// Directed self-checking bench for instr_mem_prog (MEM_SIZE=256, BASE_ADDR=0).
// ---------------------------------------------------------------------------
module tb_instr_mem_prog;

    logic        clk;
    logic        resetN;
    logic [31:0] PC;
    logic        fetch_req;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        fault;
    logic        busy;
    logic        prog_start;
    logic        prog_valid;
    logic [7:0]  prog_byte;
    logic        prog_ready;
    logic        prog_done;
    logic [8:0]  loaded_words;

    int passed = 0;
    int total  = 0;

    instr_mem_prog #(
        .MEM_SIZE  (256),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .PC           (PC),
        .fetch_req    (fetch_req),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .fault        (fault),
        .busy         (busy),
        .prog_start   (prog_start),
        .prog_valid   (prog_valid),
        .prog_byte    (prog_byte),
        .prog_ready   (prog_ready),
        .prog_done    (prog_done),
        .loaded_words (loaded_words)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic done);
        prog_valid = 1'b1;
        prog_byte  = b;
        prog_done  = done;
        tick();
        prog_valid = 1'b0;
        prog_done  = 1'b0;
    endtask

    task automatic start_load();
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
    endtask

    task automatic end_load();
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] pc, output logic v,
                            output logic [31:0] ins, output logic f);
        fetch_req = 1'b1;
        PC        = pc;
        tick();
        fetch_req = 1'b0;
        v   = instr_valid;
        ins = instruction;
        f   = fault;
        $display("fetch pc=%08h valid=%b instr=%08h fault=%b", pc, v, ins, f);
    endtask

    task automatic test_reset();
        int cnt;
        logic v, f;
        logic [31:0] ins;
        resetN = 1'b0;
        tick();
        total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault); else passed++;
        total++; if (prog_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", prog_ready); else passed++;
        total++; if (loaded_words !== 9'd0) $display("FAIL reset_loaded: got %0d expected 0", loaded_words); else passed++;
        total++; if (instruction !== 32'h0) $display("FAIL reset_instr: got %08h expected 00000000", instruction); else passed++;
        resetN = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            tick();
        end
        total++; if (cnt != 256) $display("FAIL clear_cycles: got %0d expected 256", cnt); else passed++;
        $display("clear done after %0d busy cycles", cnt);
        do_fetch(32'h20, v, ins, f);
        total++; if (v !== 1'b1) $display("FAIL clr_fetch_valid: got %b expected 1", v); else passed++;
        total++; if (ins !== 32'h0) $display("FAIL clr_fetch_instr: got %08h expected 00000000", ins); else passed++;
        total++; if (f !== 1'b0) $display("FAIL clr_fetch_fault: got %b expected 0", f); else passed++;
        tick();
        total++; if (instr_valid !== 1'b0) $display("FAIL clr_valid_pulse: got %b expected 0", instr_valid); else passed++;
    endtask

    task automatic test_load();
        logic [7:0] stream [8];
        logic v, f;
        logic [31:0] ins;
        stream = '{8'h00, 8'h21, 8'h40, 8'h20, 8'h00, 8'h01, 8'h48, 8'h20};
        start_load();
        total++; if (busy !== 1'b1) $display("FAIL load_busy: got %b expected 1", busy); else passed++;
        total++; if (prog_ready !== 1'b1) $display("FAIL load_ready: got %b expected 1", prog_ready); else passed++;
        for (int i = 0; i < 8; i++) begin
            send_byte(stream[i], 1'b0);
            $display("prog byte %0d = %02h", i, stream[i]);
        end
        end_load();
        total++; if (loaded_words !== 9'd2) $display("FAIL load_words: got %0d expected 2", loaded_words); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL load_run_busy: got %b expected 0", busy); else passed++;
        do_fetch(32'h0, v, ins, f);
        total++; if (v !== 1'b1 || ins !== 32'h00214020) $display("FAIL load_w0: got v=%b %08h expected v=1 00214020", v, ins); else passed++;
        do_fetch(32'h4, v, ins, f);
        total++; if (v !== 1'b1 || ins !== 32'h00014820) $display("FAIL load_w1: got v=%b %08h expected v=1 00014820", v, ins); else passed++;
        tick();
        total++; if (instr_valid !== 1'b0 || instruction !== 32'h00014820 || fault !== 1'b0)
            $display("FAIL idle_hold: got v=%b %08h f=%b expected v=0 00014820 f=0", instr_valid, instruction, fault);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        logic [31:0] pcs   [3];
        exp_w = '{32'h00214020, 32'h00014820, 32'h0};
        pcs   = '{32'h0, 32'h4, 32'h8};
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            PC = pcs[i];
            tick();
            $display("b2b fetch pc=%08h valid=%b instr=%08h", pcs[i], instr_valid, instruction);
            total++; if (instr_valid !== 1'b1 || instruction !== exp_w[i])
                $display("FAIL b2b_%0d: got v=%b %08h expected v=1 %08h", i, instr_valid, instruction, exp_w[i]);
            else passed++;
        end
        fetch_req = 1'b0;
        tick();
        total++; if (instr_valid !== 1'b0) $display("FAIL b2b_end: got %b expected 0", instr_valid); else passed++;
    endtask

    task automatic test_fault();
        logic v, f;
        logic [31:0] ins;
        do_fetch(32'h2, v, ins, f);
        total++; if (v !== 1'b1 || f !== 1'b1 || ins !== 32'h0)
            $display("FAIL misalign: got v=%b f=%b %08h expected v=1 f=1 00000000", v, f, ins);
        else passed++;
        do_fetch(32'h400, v, ins, f);
        total++; if (v !== 1'b1 || f !== 1'b1 || ins !== 32'h0)
            $display("FAIL out_of_range: got v=%b f=%b %08h expected v=1 f=1 00000000", v, f, ins);
        else passed++;
        do_fetch(32'h3FC, v, ins, f);
        total++; if (v !== 1'b1 || f !== 1'b0) $display("FAIL last_word: got v=%b f=%b expected v=1 f=0", v, f); else passed++;
        start_load();
        do_fetch(32'h0, v, ins, f);
        total++; if (v !== 1'b0) $display("FAIL fetch_in_load: got valid=%b expected 0", v); else passed++;
        end_load();
        total++; if (loaded_words !== 9'd0) $display("FAIL empty_load: got %0d expected 0", loaded_words); else passed++;
    endtask

    task automatic test_overflow();
        logic v, f;
        logic [31:0] ins;
        logic [31:0] word;
        start_load();
        for (int w = 0; w < 256; w++) begin
            word = {8'(w), 8'h5A, ~8'(w), 8'hC3};
            for (int k = 0; k < 4; k++) begin
                if (w == 255 && k == 3) begin
                    total++; if (prog_ready !== 1'b1) $display("FAIL ready_b1024: got %b expected 1", prog_ready); else passed++;
                end
                send_byte(word[31-8*k -: 8], 1'b0);
            end
        end
        $display("streamed 1024 bytes, prog_ready=%b", prog_ready);
        total++; if (prog_ready !== 1'b0) $display("FAIL ready_full: got %b expected 0", prog_ready); else passed++;
        send_byte(8'hEE, 1'b0);
        send_byte(8'hEE, 1'b0);
        end_load();
        total++; if (loaded_words !== 9'd256) $display("FAIL full_words: got %0d expected 256", loaded_words); else passed++;
        do_fetch(32'h3FC, v, ins, f);
        total++; if (ins !== 32'hFF5A00C3) $display("FAIL word255: got %08h expected ff5a00c3", ins); else passed++;
        do_fetch(32'h0, v, ins, f);
        total++; if (ins !== 32'h005AFFC3) $display("FAIL no_wrap_w0: got %08h expected 005affc3", ins); else passed++;
    endtask

    task automatic test_partial();
        logic v, f;
        logic [31:0] ins;
        start_load();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        total++; if (loaded_words !== 9'd1) $display("FAIL partial_words: got %0d expected 1", loaded_words); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL partial_busy: got %b expected 0", busy); else passed++;
        do_fetch(32'h0, v, ins, f);
        total++; if (ins !== 32'hAABB0000) $display("FAIL partial_w0: got %08h expected aabb0000", ins); else passed++;
        do_fetch(32'h4, v, ins, f);
        total++; if (ins !== 32'h015AFEC3) $display("FAIL partial_w1: got %08h expected 015afec3", ins); else passed++;
    endtask

    task automatic test_reset_mid_load();
        int cnt;
        logic v, f;
        logic [31:0] ins;
        start_load();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        resetN = 1'b0;
        tick();
        total++; if (busy !== 1'b1 || prog_ready !== 1'b0 || loaded_words !== 9'd0)
            $display("FAIL midload_reset: got busy=%b ready=%b words=%0d expected 1 0 0", busy, prog_ready, loaded_words);
        else passed++;
        resetN = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            tick();
        end
        total++; if (cnt != 256) $display("FAIL reclear_cycles: got %0d expected 256", cnt); else passed++;
        do_fetch(32'h0, v, ins, f);
        total++; if (v !== 1'b1 || ins !== 32'h0) $display("FAIL reclear_w0: got v=%b %08h expected v=1 00000000", v, ins); else passed++;
    endtask

    initial begin
        resetN     = 1'b0;
        PC         = '0;
        fetch_req  = 1'b0;
        prog_start = 1'b0;
        prog_valid = 1'b0;
        prog_byte  = '0;
        prog_done  = 1'b0;
        tick();
        test_reset();
        test_load();
        test_back_to_back();
        test_fault();
        test_overflow();
        test_partial();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
